reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_rdport.sv | 52 +++++
 rtl/reg_file_mp.sv | 128 ++++++++++++
 tb/tb_reg_file_mp.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and default parameters.
package reg_file_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned NRD_DEF      = 2;
    localparam int unsigned BYPASS_DEF   = 1;
    localparam int unsigned ZERO_REG_DEF = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } rfState_e;

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: address decode, write-to-read forwarding and busy lookup.
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned BYPASS   = BYPASS_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
    input  logic                                    rdy,
    input  logic [ADDR_W-1:0]                       ra,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]      regs,
    input  logic [(1<<ADDR_W)-1:0]                  busyBits,
    input  logic                                    we0,
    input  logic [ADDR_W-1:0]                       rw0,
    input  logic [DATA_W-1:0]                       wd0,
    input  logic                                    we1,
    input  logic [ADDR_W-1:0]                       rw1,
    input  logic [DATA_W-1:0]                       wd1,
    input  logic                                    mk,
    input  logic [ADDR_W-1:0]                       mkA,
    output logic [DATA_W-1:0]                       rdData_c,
    output logic                                    rdBusy_c
);

    localparam bit BYPASS_ON = (BYPASS != 0);
    localparam bit ZERO_ON   = (ZERO_REG != 0);

    logic hit0;
    logic hit1;
    logic mkHit;

    assign hit0  = we0 && (rw0 == ra);
    assign hit1  = we1 && (rw1 == ra);
    assign mkHit = mk && (mkA == ra);

    // Port 1 forwarding is applied last so it overrides port 0 on a shared address.
    always_comb begin
        rdData_c = '0;
        rdBusy_c = 1'b0;
        if (rdy && !(ZERO_ON && (ra == '0))) begin
            rdData_c = regs[ra];
            rdBusy_c = busyBits[ra];
            if (BYPASS_ON) begin
                if (hit0) rdData_c = wd0;
                if (hit1) rdData_c = wd1;
                if ((hit0 || hit1) && !mkHit) rdBusy_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, NRD read ports, busy scoreboard and a clear sweep.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NRD      = NRD_DEF,
    parameter int unsigned BYPASS   = BYPASS_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    CLR,
    input  logic                    WE0,
    input  logic                    WE1,
    input  logic [ADDR_W-1:0]       RW0,
    input  logic [ADDR_W-1:0]       RW1,
    input  logic [DATA_W-1:0]       BUSW0,
    input  logic [DATA_W-1:0]       BUSW1,
    input  logic                    MK,
    input  logic [ADDR_W-1:0]       MK_A,
    input  logic [NRD*ADDR_W-1:0]   RA,
    output logic [NRD*DATA_W-1:0]   BUSR,
    output logic [NRD-1:0]          BUSY,
    output logic                    RDY
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam bit          ZERO_ON = (ZERO_REG != 0);

    rfState_e                       state;
    logic [CNT_W-1:0]               sweepCnt;
    logic [DEPTH-1:0]               busyQ;
    logic [DEPTH-1:0]               busyNext;
    logic [DEPTH-1:0][DATA_W-1:0]   mem;
    logic                           isIdle;
    logic                           weEff0;
    logic                           weEff1;
    logic                           mkEff;

    assign isIdle = (state == IDLE);
    assign RDY    = isIdle;

    // CLR takes precedence over any same-cycle write or mark; the sweep wipes everything anyway.
    assign weEff0 = WE0 && isIdle && !CLR && !(ZERO_ON && (RW0 == '0));
    assign weEff1 = WE1 && isIdle && !CLR && !(ZERO_ON && (RW1 == '0));
    assign mkEff  = MK  && isIdle && !CLR && !(ZERO_ON && (MK_A == '0));

    // Writes release a busy bit; a mark on the same address is applied last and wins.
    always_comb begin
        busyNext = busyQ;
        if (weEff0) busyNext[RW0] = 1'b0;
        if (weEff1) busyNext[RW1] = 1'b0;
        if (mkEff)  busyNext[MK_A] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= CLEAR;
            sweepCnt <= '0;
            busyQ    <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    busyQ <= '0;
                    if (CLR) begin
                        sweepCnt <= '0;
                    end else if (sweepCnt == CNT_W'(DEPTH - 1)) begin
                        state    <= IDLE;
                        sweepCnt <= '0;
                    end else begin
                        sweepCnt <= sweepCnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (CLR) begin
                        state    <= CLEAR;
                        sweepCnt <= '0;
                        busyQ    <= '0;
                    end else begin
                        busyQ <= busyNext;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    sweepCnt <= '0;
                    busyQ    <= '0;
                end
            endcase
        end
    end

    // Storage is not reset; the sweep zeroes one entry per cycle before reads are enabled.
    always_ff @(posedge CLK) begin
        if (!isIdle) begin
            mem[sweepCnt[ADDR_W-1:0]] <= '0;
        end else begin
            if (weEff0) mem[RW0] <= BUSW0;
            if (weEff1) mem[RW1] <= BUSW1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : gRd
        reg_file_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) uRdPort (
            .rdy      (isIdle),
            .ra       (RA[k*ADDR_W +: ADDR_W]),
            .regs     (mem),
            .busyBits (busyQ),
            .we0      (weEff0),
            .rw0      (RW0),
            .wd0      (BUSW0),
            .we1      (weEff1),
            .rw1      (RW1),
            .wd1      (BUSW1),
            .mk       (mkEff),
            .mkA      (MK_A),
            .rdData_c (BUSR[k*DATA_W +: DATA_W]),
            .rdBusy_c (BUSY[k])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a forwarding instance and a non-forwarding instance share stimulus.
module tb_reg_file_mp;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CLR;
    logic        WE0, WE1;
    logic [4:0]  RW0, RW1;
    logic [31:0] BUSW0, BUSW1;
    logic        MK;
    logic [4:0]  MK_A;
    logic [9:0]  RA;
    logic [63:0] BUSR, nbBusr;
    logic [1:0]  BUSY, nbBusy;
    logic        RDY, nbRdy;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       tag;
    } sbEnt_t;

    sbEnt_t      sbQ[$];
    logic [31:0] model[32];
    logic        busyM[32];

    always #5 CLK = ~CLK;

    reg_file_mp dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .WE0(WE0), .WE1(WE1), .RW0(RW0), .RW1(RW1),
        .BUSW0(BUSW0), .BUSW1(BUSW1), .MK(MK), .MK_A(MK_A),
        .RA(RA), .BUSR(BUSR), .BUSY(BUSY), .RDY(RDY)
    );

    reg_file_mp #(.BYPASS(0)) dutNb (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .WE0(WE0), .WE1(WE1), .RW0(RW0), .RW1(RW1),
        .BUSW0(BUSW0), .BUSW1(BUSW1), .MK(MK), .MK_A(MK_A),
        .RA(RA), .BUSR(nbBusr), .BUSY(nbBusy), .RDY(nbRdy)
    );

    task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sample(input int kind);
        case (kind)
            0:       return BUSR[31:0];
            1:       return BUSR[63:32];
            2:       return 32'(BUSY[0]);
            3:       return 32'(BUSY[1]);
            4:       return 32'(RDY);
            5:       return nbBusr[31:0];
            6:       return 32'(nbBusy[0]);
            7:       return 32'(nbRdy);
            8:       return nbBusr[63:32];
            default: return 32'(nbBusy[1]);
        endcase
    endfunction

    task automatic push(input int kind, input logic [31:0] exp, input string tag);
        sbQ.push_back('{kind, exp, tag});
    endtask

    task automatic drain();
        sbEnt_t e;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            chkVal(e.tag, sample(e.kind), e.exp);
        end
    endtask

    task automatic settle();
        @(negedge CLK);
        drain();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) begin
            model[i] = '0;
            busyM[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] expData(input int a);
        logic [31:0] v;
        if (a == 0) return '0;
        v = model[a];
        if (WE0 && (int'(RW0) == a)) v = BUSW0;
        if (WE1 && (int'(RW1) == a)) v = BUSW1;
        return v;
    endfunction

    function automatic logic [31:0] expBusy(input int a);
        logic b;
        if (a == 0) return '0;
        b = busyM[a];
        if (((WE0 && (int'(RW0) == a)) || (WE1 && (int'(RW1) == a))) && !(MK && (int'(MK_A) == a)))
            b = 1'b0;
        return 32'(b);
    endfunction

    // One operational cycle: queue expectations, compare at negedge, then advance the model at the edge.
    task automatic step();
        int a0, a1;
        a0 = int'(RA[4:0]);
        a1 = int'(RA[9:5]);
        push(0, expData(a0), "rd0");
        push(1, expData(a1), "rd1");
        push(2, expBusy(a0), "busy0");
        push(3, expBusy(a1), "busy1");
        push(4, 32'd1, "rdy");
        push(5, (a0 == 0) ? 32'd0 : model[a0], "nbRd0");
        push(8, (a1 == 0) ? 32'd0 : model[a1], "nbRd1");
        push(6, (a0 == 0) ? 32'd0 : 32'(busyM[a0]), "nbBusy0");
        push(9, (a1 == 0) ? 32'd0 : 32'(busyM[a1]), "nbBusy1");
        push(7, 32'd1, "nbRdy");
        settle();
        @(posedge CLK);
        if (WE0 && RW0 != 5'd0) begin model[RW0] = BUSW0; busyM[RW0] = 1'b0; end
        if (WE1 && RW1 != 5'd0) begin model[RW1] = BUSW1; busyM[RW1] = 1'b0; end
        if (MK && MK_A != 5'd0) busyM[MK_A] = 1'b1;
        #1;
    endtask

    task automatic sweepChk(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            push(4, 32'd0, tag);
            push(7, 32'd0, tag);
            push(0, 32'd0, tag);
            push(2, 32'd0, tag);
            settle();
            tick();
        end
    endtask

    initial begin
        RST_N = 1'b0; CLR = 1'b0;
        WE0 = 1'b0; WE1 = 1'b0; RW0 = '0; RW1 = '0;
        BUSW0 = '0; BUSW1 = '0; MK = 1'b0; MK_A = '0; RA = '0;
        clearModel();

        // Reset state, then exactly 32 not-ready cycles after release.
        #3;
        push(4, 32'd0, "rst_rdy");
        push(2, 32'd0, "rst_busy");
        drain();
        tick();
        RST_N = 1'b1;
        sweepChk(32, "init_sweep");

        for (int i = 0; i < 16; i++) begin
            RA = {5'(31 - i), 5'(i)};
            step();
        end

        // Same-cycle forwarding versus pre-edge contents.
        RA = {5'd0, 5'd3};
        WE0 = 1'b1; RW0 = 5'd3; BUSW0 = 32'hA5A5_A5A5;
        push(0, 32'hA5A5_A5A5, "byp_same");
        push(5, 32'h0, "nobyp_old");
        step();
        WE0 = 1'b0;
        push(5, 32'hA5A5_A5A5, "nobyp_next");
        step();

        // Write-port collision and address-0 writes.
        RA = {5'd0, 5'd7};
        WE0 = 1'b1; RW0 = 5'd7; BUSW0 = 32'h11;
        WE1 = 1'b1; RW1 = 5'd7; BUSW1 = 32'h22;
        push(0, 32'h22, "dual_byp");
        step();
        WE1 = 1'b0; RW0 = 5'd0; BUSW0 = 32'hFF;
        push(0, 32'h22, "reg7");
        push(1, 32'h0, "zero_byp");
        step();
        WE0 = 1'b0;
        push(1, 32'h0, "reg0");
        step();

        // Busy scoreboard: mark, clear by write, mark wins over a same-cycle write.
        RA = {5'd0, 5'd9};
        MK = 1'b1; MK_A = 5'd9;
        step();
        MK = 1'b0;
        push(2, 32'd1, "mk_set");
        step();
        WE1 = 1'b1; RW1 = 5'd9; BUSW1 = 32'h99;
        push(2, 32'd0, "wr_byp_busy");
        step();
        WE1 = 1'b0;
        push(2, 32'd0, "wr_clr");
        step();
        MK = 1'b1; WE0 = 1'b1; RW0 = 5'd9; BUSW0 = 32'h55;
        step();
        MK = 1'b0; WE0 = 1'b0;
        push(2, 32'd1, "mk_wins");
        push(0, 32'h55, "mk_data");
        step();

        // Random traffic on a narrow address range to force collisions.
        for (int i = 0; i < 60; i++) begin
            WE0 = 1'($urandom_range(0, 1)); RW0 = 5'($urandom_range(0, 7)); BUSW0 = $urandom;
            WE1 = 1'($urandom_range(0, 1)); RW1 = 5'($urandom_range(0, 7)); BUSW1 = $urandom;
            MK = ($urandom_range(0, 3) == 0); MK_A = 5'($urandom_range(0, 7));
            RA = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            step();
        end
        WE0 = 1'b0; WE1 = 1'b0; MK = 1'b0;

        // CLR mid-sweep restarts the count; writes during the sweep are ignored.
        WE0 = 1'b1; RW0 = 5'd5; BUSW0 = 32'h5555; MK = 1'b1; MK_A = 5'd6;
        step();
        WE0 = 1'b0; MK = 1'b0;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        WE0 = 1'b1; RW0 = 5'd5; BUSW0 = 32'h0BAD;
        sweepChk(20, "clr_sweep");
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        sweepChk(32, "clr_restart");
        WE0 = 1'b0;
        clearModel();
        RA = {5'd6, 5'd5};
        push(0, 32'h0, "clr_wr5");
        push(3, 32'h0, "clr_busy6");
        step();

        // Reset asserted during a write cycle.
        WE1 = 1'b1; RW1 = 5'd12; BUSW1 = 32'h1234; MK = 1'b1; MK_A = 5'd13;
        step();
        WE1 = 1'b0; MK = 1'b0;
        WE0 = 1'b1; RW0 = 5'd12; BUSW0 = 32'hDEAD; RA = {5'd13, 5'd12};
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        push(4, 32'd0, "rst_mid_rdy");
        push(3, 32'd0, "rst_mid_busy");
        push(0, 32'd0, "rst_mid_rd");
        drain();
        tick();
        RST_N = 1'b1;
        sweepChk(32, "rst_sweep");
        WE0 = 1'b0;
        clearModel();
        push(0, 32'h0, "rst_wr12");
        push(3, 32'h0, "rst_busy13");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
